counter_seq_ctrl: RTL

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - two-level nested index sequencer with valid/ready handshake
// Emits (inner, outer) index pairs from latched loop bounds; abort and reset end a sequence early.
module counter_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_start,
  input  logic [WIDTH-1:0] in_end,
  input  logic [WIDTH-1:0] in_step,
  input  logic [WIDTH-1:0] out_start,
  input  logic [WIDTH-1:0] out_end,
  input  logic [WIDTH-1:0] out_step,
  input  logic             idx_ready,
  output logic             idx_valid,
  output logic [WIDTH-1:0] idx_in,
  output logic [WIDTH-1:0] idx_out,
  output logic             idx_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] idx_in_q, idx_in_d;
  logic [WIDTH-1:0] idx_out_q, idx_out_d;
  logic [WIDTH-1:0] in_start_q, in_start_d;
  logic [WIDTH-1:0] in_end_q, in_end_d;
  logic [WIDTH-1:0] in_step_q, in_step_d;
  logic [WIDTH-1:0] out_start_q, out_start_d;
  logic [WIDTH-1:0] out_end_q, out_end_d;
  logic [WIDTH-1:0] out_step_q, out_step_d;

  logic in_at_end;
  logic out_at_end;
  logic handshake;

  assign in_at_end  = (idx_in_q == in_end_q);
  assign out_at_end = (idx_out_q == out_end_q);
  assign handshake  = (state_q == RUN) && idx_ready;

  always_comb begin
    state_d     = state_q;
    idx_in_d    = idx_in_q;
    idx_out_d   = idx_out_q;
    in_start_d  = in_start_q;
    in_end_d    = in_end_q;
    in_step_d   = in_step_q;
    out_start_d = out_start_q;
    out_end_d   = out_end_q;
    out_step_d  = out_step_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          in_start_d  = in_start;
          in_end_d    = in_end;
          in_step_d   = in_step;
          out_start_d = out_start;
          out_end_d   = out_end;
          out_step_d  = out_step;
          idx_in_d    = in_start;
          idx_out_d   = out_start;
          state_d     = RUN;
        end
      end
      RUN: begin
        // Abort wins over a handshake in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (handshake) begin
          if (!in_at_end) begin
            idx_in_d = idx_in_q + in_step_q;
          end else if (!out_at_end) begin
            idx_in_d  = in_start_q;
            idx_out_d = idx_out_q + out_step_q;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_in_q    <= '0;
      idx_out_q   <= '0;
      in_start_q  <= '0;
      in_end_q    <= '0;
      in_step_q   <= '0;
      out_start_q <= '0;
      out_end_q   <= '0;
      out_step_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_in_q    <= idx_in_d;
      idx_out_q   <= idx_out_d;
      in_start_q  <= in_start_d;
      in_end_q    <= in_end_d;
      in_step_q   <= in_step_d;
      out_start_q <= out_start_d;
      out_end_q   <= out_end_d;
      out_step_q  <= out_step_d;
    end
  end

  assign idx_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign idx_in    = idx_in_q;
  assign idx_out   = idx_out_q;
  assign idx_last  = in_at_end && out_at_end && (state_q == RUN);

endmodule
